// File: rtl/kss_pkg.sv
// kss_pkg: shared definitions for the pipelined Kogge-Stone subtractor.
//   KSS_WIDTH   - operand width handled by the fixed 3-level prefix network
//   KSS_LATENCY - number of register stages between operand and result
//   pg_t        - per-bit (or per-group) propagate/generate pair
package kss_pkg;

    localparam int KSS_WIDTH   = 8;
    localparam int KSS_LATENCY = 3;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

endpackage

// File: rtl/kss_prefix_cell.sv
// kss_prefix_cell: Kogge-Stone combine node.
//   hi  - propagate/generate of the more significant span
//   lo  - propagate/generate of the adjacent less significant span
//   grp - combined span: g = hi.g | hi.p & lo.g, p = hi.p & lo.p
// GEN_ONLY = 1 is used where the lower span already reaches the carry-in.
// The combined span is then fully resolved, so its propagate is never
// consumed and is tied low instead of building the AND term.
import kss_pkg::*;

module kss_prefix_cell #(
    parameter bit GEN_ONLY = 1'b0
) (
    input  pg_t hi,
    input  pg_t lo,
    output pg_t grp
);

    always_comb begin
        grp.g = hi.g | (hi.p & lo.g);
        grp.p = GEN_ONLY ? 1'b0 : (hi.p & lo.p);
    end

endmodule

// File: rtl/kogge_stone_sub8_pipe.sv
// kogge_stone_sub8_pipe: pipelined 8-bit parallel-prefix subtractor.
// Computes D = A - B - Bi as A + ~B + ~Bi, so the prefix network carry-in
// is ~Bi and the borrow-out is the inverted carry-out.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle (combinational from out_ready)
//   A, B, Bi   minuend, subtrahend, borrow-in
//   out_valid  result valid
//   out_ready  consumer takes the result this cycle
//   D, Bo      difference and borrow-out
//   V          signed overflow, only when KSS_OVERFLOW_EN is defined
//
// Stages:
//   S0 - per-bit P/G of A and ~B, carry-in
//   S1 - prefix levels 1 and 2 (distance 1, 2), carry-in folded into bit 0
//   S2 - prefix level 3 (distance 4), sum, borrow-out, overflow
// The whole pipe advances together on enable = ~out_valid | out_ready, so
// bubbles are kept but no beat is dropped or repeated.
import kss_pkg::*;

module kogge_stone_sub8_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bo
`ifdef KSS_OVERFLOW_EN
   ,output logic             V
`endif
);

    logic                   en;
    logic [KSS_LATENCY-1:0] vld;

    pg_t [KSS_WIDTH-1:0]    e_pg;

    pg_t [KSS_WIDTH-1:0]    s0_pg;
    logic                   s0_cin;
    logic [KSS_WIDTH-1:0]   s0_p;

    pg_t                    cin_pg;
    pg_t [KSS_WIDTH-1:0]    l0;
    pg_t [KSS_WIDTH-1:0]    l1;
    pg_t [KSS_WIDTH-1:0]    l2;

    pg_t [KSS_WIDTH-1:0]    s1_grp;
    logic [KSS_WIDTH-1:0]   s1_p;
    logic                   s1_cin;

    pg_t [KSS_WIDTH-1:0]    l3;
    logic [KSS_WIDTH-1:0]   l3_p;
    logic [KSS_WIDTH-1:0]   carry;
    logic [KSS_WIDTH-1:0]   sum;
    logic                   co;
    logic                   unused_p;

`ifdef KSS_OVERFLOW_EN
    logic                   s0_a7;
    logic                   s0_b7;
    logic                   s1_a7;
    logic                   s1_b7;
`endif

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign out_valid = vld[KSS_LATENCY-1];
    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;

    // ------------------------------------------------------------------
    // Entry: propagate/generate of A against the inverted subtrahend
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < KSS_WIDTH; i++) begin
            e_pg[i].p = A[i] ^ ~B[i];
            e_pg[i].g = A[i] & ~B[i];
        end
    end

    for (genvar i = 0; i < KSS_WIDTH; i++) begin : g_s0_p
        assign s0_p[i] = s0_pg[i].p;
    end

    // ------------------------------------------------------------------
    // Prefix levels 1 and 2 (between S0 and S1)
    // The carry-in is treated as a span below bit 0 and folded in first;
    // after the level at distance d, bits below 2*d are fully resolved,
    // which is why nodes with i < 2*d use the generate-only cell.
    // ------------------------------------------------------------------
    always_comb begin
        cin_pg.p = 1'b0;
        cin_pg.g = s0_cin;
    end

    kss_prefix_cell #(.GEN_ONLY(1'b1)) u_cin_fold (
        .hi  (s0_pg[0]),
        .lo  (cin_pg),
        .grp (l0[0])
    );

    for (genvar i = 1; i < KSS_WIDTH; i++) begin : g_lvl0
        assign l0[i] = s0_pg[i];
    end

    for (genvar i = 0; i < KSS_WIDTH; i++) begin : g_lvl1
        if (i < 1) begin : g_pass
            assign l1[i] = l0[i];
        end else begin : g_node
            kss_prefix_cell #(.GEN_ONLY(i < 2)) u_cell (
                .hi  (l0[i]),
                .lo  (l0[i-1]),
                .grp (l1[i])
            );
        end
    end

    for (genvar i = 0; i < KSS_WIDTH; i++) begin : g_lvl2
        if (i < 2) begin : g_pass
            assign l2[i] = l1[i];
        end else begin : g_node
            kss_prefix_cell #(.GEN_ONLY(i < 4)) u_cell (
                .hi  (l1[i]),
                .lo  (l1[i-2]),
                .grp (l2[i])
            );
        end
    end

    // ------------------------------------------------------------------
    // Prefix level 3 (between S1 and S2): every node ends resolved
    // ------------------------------------------------------------------
    for (genvar i = 0; i < KSS_WIDTH; i++) begin : g_lvl3
        if (i < 4) begin : g_pass
            assign l3[i] = s1_grp[i];
        end else begin : g_node
            kss_prefix_cell #(.GEN_ONLY(1'b1)) u_cell (
                .hi  (s1_grp[i]),
                .lo  (s1_grp[i-4]),
                .grp (l3[i])
            );
        end
        assign l3_p[i] = l3[i].p;
    end

    // Group propagates are meaningless once every span is resolved.
    assign unused_p = ^l3_p;

    // ------------------------------------------------------------------
    // Sum and carry-out: l3[i].g is the carry out of bit i
    // ------------------------------------------------------------------
    always_comb begin
        carry[0] = s1_cin;
        for (int i = 1; i < KSS_WIDTH; i++) begin
            carry[i] = l3[i-1].g;
        end
        sum = s1_p ^ carry;
        co  = l3[KSS_WIDTH-1].g;
    end

    // ------------------------------------------------------------------
    // Stage registers; data registers load only behind a valid beat
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld    <= '0;
            s0_pg  <= '0;
            s0_cin <= 1'b0;
            s1_grp <= '0;
            s1_p   <= '0;
            s1_cin <= 1'b0;
            D      <= '0;
            Bo     <= 1'b0;
        end else if (en) begin
            vld <= {vld[KSS_LATENCY-2:0], in_valid};
            if (in_valid) begin
                s0_pg  <= e_pg;
                s0_cin <= ~Bi;
            end
            if (vld[0]) begin
                s1_grp <= l2;
                s1_p   <= s0_p;
                s1_cin <= s0_cin;
            end
            if (vld[1]) begin
                D  <= sum;
                Bo <= ~co;
            end
        end
    end

`ifdef KSS_OVERFLOW_EN
    // Operand sign bits ride along so V uses the same beat's operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_a7 <= 1'b0;
            s0_b7 <= 1'b0;
            s1_a7 <= 1'b0;
            s1_b7 <= 1'b0;
            V     <= 1'b0;
        end else if (en) begin
            if (in_valid) begin
                s0_a7 <= A[KSS_WIDTH-1];
                s0_b7 <= B[KSS_WIDTH-1];
            end
            if (vld[0]) begin
                s1_a7 <= s0_a7;
                s1_b7 <= s0_b7;
            end
            if (vld[1]) begin
                V <= (s1_a7 ^ s1_b7) & (sum[KSS_WIDTH-1] ^ s1_a7);
            end
        end
    end
`endif

endmodule
